// File: rtl/ycbcr_src_arbiter_pkg.sv
// Shared types and defaults for the YCbCr source arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ycbcr_src_arbiter_pkg;

  localparam int DW_DEF    = 24;   // pixel width: R[23:16], B[15:8], G[7:0]
  localparam int LINES_DEF = 720;  // tlast beats per frame

  // SYNC: no frame in progress, PASS: forwarding a frame from cur_src
  typedef enum logic {
    SYNC = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  // Width of a counter holding 0..lines-1 (at least one bit).
  function automatic int line_cnt_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single register stage for an AXI4-Stream video bus (data, last, user).
// Latency: 1 cycle, full throughput while m_tready is high.
// Backpressure: s_tready = !m_tvalid || m_tready; outputs held stable while stalled.
//
// Ports: clk, rst (sync, active high); s_t* upstream side; m_t* downstream side.
module axis_reg_slice
  import ycbcr_src_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  input  logic          s_tuser,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          m_tuser
);

  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tlast <= s_tlast;
        m_tuser <= s_tuser;
      end
    end
  end

endmodule

// File: rtl/ycbcr_src_arbiter.sv
// Frame-aligned 2:1 video source selector feeding the YCbCr converter.
// Latency: 1 cycle (output register stage), full throughput.
// Backpressure: granted input sees downstream backpressure; non-granted input is always ready and dropped.
//
// Ports: clk, rst (sync, active high); sel requested source (0 camera, 1 still);
//        s0_t*/s1_t* input streams (tuser = SOF, tlast = EOL); m_t* output stream;
//        cur_src granted source; sof_err pulse on mid-frame SOF; frame_cnt completed frames.
module ycbcr_src_arbiter
  import ycbcr_src_arbiter_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LINES = LINES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic [DW-1:0] s0_tdata,
  input  logic          s0_tvalid,
  output logic          s0_tready,
  input  logic          s0_tlast,
  input  logic          s0_tuser,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  output logic          s1_tready,
  input  logic          s1_tlast,
  input  logic          s1_tuser,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          m_tuser,
  output logic          cur_src,
  output logic          sof_err,
  output logic [15:0]   frame_cnt
);

  localparam int            LW        = line_cnt_w(LINES);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

  arb_state_t    state;
  logic [LW-1:0] line_cnt;
  logic [LW-1:0] line_base;

  logic [DW-1:0] g_tdata;
  logic          g_tvalid;
  logic          g_tlast;
  logic          g_tuser;
  logic          slice_rdy;
  logic          g_rdy;
  logic          xfer;
  logic          fwd;
  logic          eof;

  // Granted stream mux
  assign g_tdata  = cur_src ? s1_tdata  : s0_tdata;
  assign g_tvalid = cur_src ? s1_tvalid : s0_tvalid;
  assign g_tlast  = cur_src ? s1_tlast  : s0_tlast;
  assign g_tuser  = cur_src ? s1_tuser  : s0_tuser;

  // Non-granted input is drained unconditionally so a camera never stalls.
  assign g_rdy     = !rst && slice_rdy;
  assign s0_tready = !rst && (cur_src ? 1'b1 : slice_rdy);
  assign s1_tready = !rst && (cur_src ? slice_rdy : 1'b1);

  assign xfer = g_tvalid && g_rdy;
  // Outside a frame only an SOF beat gets through; everything else is dropped.
  assign fwd  = xfer && (state == PASS || g_tuser);

  // SOF (first or resync) restarts line counting before its own tlast is applied,
  // so a beat with both tuser and tlast leaves the counter at 1.
  assign line_base = (state == SYNC || g_tuser) ? '0 : line_cnt;
  assign eof       = g_tlast && (line_base == LAST_LINE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      cur_src   <= 1'b0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      sof_err   <= 1'b0;
    end else begin
      sof_err <= fwd && (state == PASS) && g_tuser;
      if (fwd) begin
        if (eof) begin
          line_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          state     <= SYNC;
        end else begin
          line_cnt <= line_base + LW'(g_tlast);
          state    <= PASS;
        end
      end
      // sel is only honoured between frames; hold it on the cycle an SOF is taken.
      if (state == SYNC && !fwd) begin
        cur_src <= sel;
      end
    end
  end

  axis_reg_slice #(.DW(DW)) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (g_tdata),
    .s_tvalid (g_tvalid && (state == PASS || g_tuser) && !rst),
    .s_tready (slice_rdy),
    .s_tlast  (g_tlast),
    .s_tuser  (g_tuser),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser)
  );

endmodule

// File: tb/tb_ycbcr_src_arbiter.sv
`timescale 1ns/1ps
module tb_ycbcr_src_arbiter;

  localparam int DW    = 24;
  localparam int LINES = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    beat_t b;
    int    acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic [DW-1:0] s0_tdata = '0;
  logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0;
  logic          s0_tready;
  logic [DW-1:0] s1_tdata = '0;
  logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0;
  logic          s1_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b1;
  logic          cur_src, sof_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  ycbcr_src_arbiter #(.DW(DW), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .cur_src(cur_src), .sof_err(sof_err), .frame_cnt(frame_cnt)
  );

  int n_chk = 0, n_fail = 0, cyc = 0, n_pop = 0, n_sof = 0;
  beat_t q0[$], q1[$];
  exp_t  exp_q[$];
  int    sof_q[$];

  // Reference model: frame-level view of the arbiter
  bit          in_frame = 0;
  bit          m_src    = 0;
  int          m_line   = 0;
  logic [15:0] m_frames = '0;

  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int gap      = 0;   // percent chance a queued beat is withheld
  bit lat_chk  = 0;
  bit flush    = 0;
  bit hold0 = 0, hold1 = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive inputs, update model, advance to the next negedge.
  task automatic tick();
    beat_t b;
    bit hs0, hs1, g_hs, start_sync, took;
    if (q0.size() > 0 && (hold0 || $urandom_range(99) >= gap)) begin
      s0_tvalid = 1'b1; {s0_tdata, s0_tlast, s0_tuser} = q0[0];
    end else begin
      s0_tvalid = 1'b0; s0_tdata = DW'($urandom); s0_tlast = 1'($urandom); s0_tuser = 1'($urandom);
    end
    if (q1.size() > 0 && (hold1 || $urandom_range(99) >= gap)) begin
      s1_tvalid = 1'b1; {s1_tdata, s1_tlast, s1_tuser} = q1[0];
    end else begin
      s1_tvalid = 1'b0; s1_tdata = DW'($urandom); s1_tlast = 1'($urandom); s1_tuser = 1'($urandom);
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      default: m_tready = ($urandom_range(99) < 70);
    endcase
    #1;
    hs0 = s0_tvalid && s0_tready;
    hs1 = s1_tvalid && s1_tready;
    if (rst) begin
      flush = 1; in_frame = 0; m_src = 0; m_line = 0; m_frames = '0;
    end else begin
      chk("cur_src", cur_src, m_src);
      if (m_src) chk("s0_tready_ungranted", s0_tready, 1);
      else       chk("s1_tready_ungranted", s1_tready, 1);
      g_hs = m_src ? hs1 : hs0;
      b = m_src ? {s1_tdata, s1_tlast, s1_tuser} : {s0_tdata, s0_tlast, s0_tuser};
      start_sync = !in_frame;
      took = 0;
      if (g_hs && (in_frame || b.user)) begin
        exp_q.push_back('{b: b, acc: cyc + 1});
        if (b.user) begin
          if (in_frame) sof_q.push_back(cyc + 1);
          took = !in_frame;
          in_frame = 1;
          m_line = 0;
        end
        if (b.last) begin
          m_line++;
          if (m_line == LINES) begin
            m_line = 0; m_frames++; in_frame = 0;
          end
        end
      end
      if (start_sync && !took) m_src = sel;
    end
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    hold0 = s0_tvalid && !hs0;
    hold1 = s1_tvalid && !hs1;
    @(posedge clk);
    cyc++;
    if (flush) begin
      exp_q.delete(); sof_q.delete(); flush = 0;
    end
    @(negedge clk);
  endtask

  // Output monitor / scoreboard
  bit    stalled = 0;
  beat_t held;
  exp_t  e;
  bit    exp_sof;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      exp_sof = (sof_q.size() > 0 && sof_q[0] == cyc);
      if (exp_sof) void'(sof_q.pop_front());
      if (sof_err || exp_sof) chk("sof_err", sof_err, exp_sof);
      if (sof_err) n_sof++;
      if (stalled) chk("stall_hold", {m_tvalid, m_tdata, m_tlast, m_tuser}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat: got %0h, want no beat (cycle %0d)",
                   {m_tdata, m_tlast, m_tuser}, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("m_beat", {m_tdata, m_tlast, m_tuser}, e.b);
          if (lat_chk) chk("latency", cyc, e.acc);
          n_pop++;
        end
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tdata, m_tlast, m_tuser};
    end else begin
      stalled = 0;
    end
  end

  task automatic add_frame(input bit src, input int px, input int n_lines, input int xsof_line);
    beat_t b;
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < px; p++) begin
        b.d    = {src, 23'($urandom)};
        b.last = (p == px - 1);
        b.user = (p == 0) && (l == 0 || l == xsof_line);
        if (src) q1.push_back(b); else q0.push_back(b);
      end
    end
  endtask

  task automatic add_junk(input bit src, input int n, input bit allow_user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {src, 23'($urandom)}; b.last = 1'($urandom);
      b.user = allow_user ? 1'($urandom) : 1'b0;
      if (src) q1.push_back(b); else q0.push_back(b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    tick(); tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run(input int limit);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < limit) begin
      tick(); n++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout: got %0d beats left, want 0", q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    drain();
  endtask

  task automatic run_until_left(input bit src, input int left);
    for (int i = 0; i < 500; i++) begin
      if ((src ? q1.size() : q0.size()) <= left) return;
      tick();
    end
    n_chk++; n_fail++;
    $display("FAIL wait_timeout: got queue not down to %0d, want reached", left);
  endtask

  int f0, p0, s0c;

  initial begin
    // Reset state
    rst = 1; tick(); tick();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
    rst = 0;

    // No SOF yet: s0 beats without tuser are discarded, then a frame
    sel = 0;
    add_junk(0, 6, 0);
    run(200);
    chk("no_sof_frames", frame_cnt, 0);
    add_frame(0, 3, 4, -1);
    run(200);
    chk("first_frame_cnt", frame_cnt, 1);

    // Two camera frames, always-ready output, s1 noise dropped
    f0 = m_frames; p0 = n_pop; lat_chk = 1;
    add_frame(0, 3, 4, -1); add_frame(0, 3, 4, -1);
    add_junk(1, 20, 1);
    run(400);
    lat_chk = 0;
    chk("two_frames_beats", n_pop - p0, 24);
    chk("two_frames_cnt", frame_cnt, f0 + 2);

    // Source switch requested mid-frame takes effect after the frame
    add_frame(0, 3, 4, -1);
    run_until_left(0, 8);
    sel = 1;
    run(200);
    chk("switch_cur_src", cur_src, 1);
    p0 = n_pop;
    add_junk(1, 3, 0); add_frame(1, 3, 4, -1);
    run(200);
    chk("switch_s1_beats", n_pop - p0, 12);
    chk("switch_frame_cnt", frame_cnt, m_frames);

    // sel reverting within a frame causes no switch
    add_frame(1, 3, 4, -1);
    run_until_left(1, 8);
    sel = 0; tick(); tick(); sel = 1;
    run(200);
    chk("revert_cur_src", cur_src, 1);

    // Output backpressure toggling every cycle
    sel = 0; tick(); tick(); tick();
    rdy_mode = 1; f0 = m_frames;
    add_frame(0, 3, 4, -1);
    run(400);
    rdy_mode = 0;
    chk("toggle_frame_cnt", frame_cnt, f0 + 1);

    // Extra SOF inside a frame
    f0 = m_frames; s0c = n_sof;
    add_frame(0, 3, 6, 2);
    run(400);
    chk("resync_sof_pulses", n_sof - s0c, 1);
    chk("resync_frame_cnt", frame_cnt, f0 + 1);

    // Reset mid-frame
    add_frame(0, 3, 4, -1);
    run_until_left(0, 7);
    rst = 1; tick(); rst = 0;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    run(200);
    chk("midrst_no_resume", frame_cnt, 0);
    add_frame(0, 3, 4, -1);
    run(200);
    chk("midrst_resume_cnt", frame_cnt, 1);

    // Randomized mix: both sources, random sel, stalls, 1-px lines, resyncs
    rdy_mode = 2; gap = 30;
    for (int it = 0; it < 30; it++) begin
      sel = 1'($urandom);
      for (int s = 0; s < 2; s++) begin
        int px, xs;
        px = $urandom_range(1, 3);
        xs = ($urandom_range(3) == 0) ? 2 : -1;
        if ($urandom_range(1)) add_junk(1'(s), $urandom_range(0, 3), 0);
        add_frame(1'(s), px, (xs < 0) ? 4 : 6, xs);
      end
      run(3000);
      chk("rand_frame_cnt", frame_cnt, m_frames);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
